// File: rtl/fb_buf_sched_if.sv
// Writer/reader handshake bundle for the frame-buffer scheduler: buffer base
// addresses and sof pulses in, per-frame buffer selection and status out.
interface fb_buf_sched_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] buf_addr0;
  logic [ADDR_WIDTH-1:0] buf_addr1;
  logic [ADDR_WIDTH-1:0] buf_addr2;
  logic [ADDR_WIDTH-1:0] buf_addr3;
  logic                  s2mm_sof;
  logic [ADDR_WIDTH-1:0] s2mm_addr;
  logic [1:0]            s2mm_idx;
  logic                  mm2s_sof;
  logic [ADDR_WIDTH-1:0] mm2s_addr;
  logic [1:0]            mm2s_idx;
  logic                  frame_avail;
  logic [1:0]            latest_idx;
  logic [CNT_WIDTH-1:0]  drop_cnt;

  // Stream side: supplies buffer addresses and frame starts.
  modport master (
    output buf_addr0, buf_addr1, buf_addr2, buf_addr3, s2mm_sof, mm2s_sof,
    input  s2mm_addr, s2mm_idx, mm2s_addr, mm2s_idx, frame_avail, latest_idx, drop_cnt
  );

  // Scheduler side.
  modport slave (
    input  buf_addr0, buf_addr1, buf_addr2, buf_addr3, s2mm_sof, mm2s_sof,
    output s2mm_addr, s2mm_idx, mm2s_addr, mm2s_idx, frame_avail, latest_idx, drop_cnt
  );
endinterface

// File: rtl/fb_buf_sched.sv
// Triple/quad frame-buffer scheduler: keeps the writer off the buffer the
// reader holds, hands the reader the newest complete frame, counts overwrites.
module fb_buf_sched #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_BUF_NUM    = 3,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          reset,
  fb_buf_sched_if.slave bus
);

  localparam logic [2:0] BUF_NUM = 3'(C_BUF_NUM);

  logic [C_ADDR_WIDTH-1:0] buf_addr [4];
  assign buf_addr[0] = bus.buf_addr0;
  assign buf_addr[1] = bus.buf_addr1;
  assign buf_addr[2] = bus.buf_addr2;
  assign buf_addr[3] = bus.buf_addr3;

  logic [1:0]              wr_idx, rd_idx, latest_idx;
  logic                    wr_started, latest_valid, latest_read, rd_active;
  logic [C_CNT_WIDTH-1:0]  drop_cnt;
  logic [C_ADDR_WIDTH-1:0] s2mm_addr, mm2s_addr;

  logic       rd_take, wr_done, drop_hit;
  logic [1:0] rd_next, wr_next, wr_inc1, wr_inc2;

  function automatic logic [1:0] idx_add(input logic [1:0] idx, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, idx} + {1'b0, step};
    if (sum >= BUF_NUM) sum = sum - BUF_NUM;
    return sum[1:0];
  endfunction

  // The reader step is resolved first so the writer can steer around rd_next.
  // rd_active keeps a reader that has never held a frame from blocking the writer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    rd_take  = bus.mm2s_sof & latest_valid;
    rd_next  = rd_idx;
    wr_done  = bus.s2mm_sof & wr_started;
    wr_inc1  = idx_add(wr_idx, 2'd1);
    wr_inc2  = idx_add(wr_idx, 2'd2);
    wr_next  = wr_idx;
    drop_hit = 1'b0;

    if (rd_take) rd_next = latest_idx;

    if (wr_done) begin
      wr_next  = ((rd_active | rd_take) && (wr_inc1 == rd_next)) ? wr_inc2 : wr_inc1;
      // A frame the reader grabs in this very cycle is not a drop.
      drop_hit = latest_valid & ~latest_read & ~rd_take;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      latest_idx   <= '0;
      wr_started   <= 1'b0;
      latest_valid <= 1'b0;
      latest_read  <= 1'b0;
      rd_active    <= 1'b0;
      drop_cnt     <= '0;
      s2mm_addr    <= '0;
      mm2s_addr    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      wr_idx <= wr_next;
      rd_idx <= rd_next;
      if (bus.s2mm_sof) wr_started <= 1'b1;
      if (rd_take) begin
        rd_active   <= 1'b1;
        latest_read <= 1'b1;
      end
      // A newly completed frame is unread even if the reader took the old one.
      if (wr_done) begin
        latest_idx   <= wr_idx;
        latest_valid <= 1'b1;
        latest_read  <= 1'b0;
      end
      if (drop_hit && (drop_cnt != '1)) drop_cnt <= drop_cnt + C_CNT_WIDTH'(1);
      s2mm_addr <= buf_addr[wr_next];
      mm2s_addr <= buf_addr[rd_next];
    end
  end

  assign bus.s2mm_addr   = s2mm_addr;
  assign bus.s2mm_idx    = wr_idx;
  assign bus.mm2s_addr   = mm2s_addr;
  assign bus.mm2s_idx    = rd_idx;
  assign bus.frame_avail = latest_valid;
  assign bus.latest_idx  = latest_idx;
  assign bus.drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_fb_buf_sched.sv
// Directed bench for fb_buf_sched: three instances (3 buffers, 4 buffers,
// 2-bit drop counter) checked through an expected-result queue.
module tb_fb_buf_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  fb_buf_sched_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus0 ();
  fb_buf_sched_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus1 ();
  fb_buf_sched_if #(.ADDR_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

  fb_buf_sched #(.C_ADDR_WIDTH(32), .C_BUF_NUM(3), .C_CNT_WIDTH(16))
    dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  fb_buf_sched #(.C_ADDR_WIDTH(32), .C_BUF_NUM(4), .C_CNT_WIDTH(16))
    dut1 (.clk(clk), .reset(rst1), .bus(bus1));
  fb_buf_sched #(.C_ADDR_WIDTH(32), .C_BUF_NUM(3), .C_CNT_WIDTH(2))
    dut2 (.clk(clk), .reset(rst2), .bus(bus2));

  typedef struct {
    string       tag;
    int          d;
    logic [1:0]  wr, rd, lat;
    logic        av;
    logic [15:0] drop;
    logic [31:0] waddr, raddr;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] buf_of(input int i);
    return 32'h1000 * (i + 1);
  endfunction

  function automatic exp_t mk(input string tag, input int d, input int wr, input int rd,
                              input int lat, input int av, input int drop);
    exp_t e;
    e.tag = tag; e.d = d;
    e.wr = 2'(wr); e.rd = 2'(rd); e.lat = 2'(lat);
    e.av = (av != 0); e.drop = 16'(drop);
    e.waddr = buf_of(wr); e.raddr = buf_of(rd);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    logic [1:0] wr, rd, lat;
    logic av;
    logic [15:0] drop;
    logic [31:0] wa, ra;
    e = sb.pop_front();
    case (e.d)
      0: begin wr = bus0.s2mm_idx; rd = bus0.mm2s_idx; lat = bus0.latest_idx; av = bus0.frame_avail;
               drop = bus0.drop_cnt; wa = bus0.s2mm_addr; ra = bus0.mm2s_addr; end
      1: begin wr = bus1.s2mm_idx; rd = bus1.mm2s_idx; lat = bus1.latest_idx; av = bus1.frame_avail;
               drop = bus1.drop_cnt; wa = bus1.s2mm_addr; ra = bus1.mm2s_addr; end
      default: begin wr = bus2.s2mm_idx; rd = bus2.mm2s_idx; lat = bus2.latest_idx; av = bus2.frame_avail;
               drop = 16'(bus2.drop_cnt); wa = bus2.s2mm_addr; ra = bus2.mm2s_addr; end
    endcase
    check({e.tag, ".s2mm_idx"},    32'(wr),   32'(e.wr));
    check({e.tag, ".mm2s_idx"},    32'(rd),   32'(e.rd));
    check({e.tag, ".latest_idx"},  32'(lat),  32'(e.lat));
    check({e.tag, ".frame_avail"}, 32'(av),   32'(e.av));
    check({e.tag, ".drop_cnt"},    32'(drop), 32'(e.drop));
    check({e.tag, ".s2mm_addr"},   wa,        e.waddr);
    check({e.tag, ".mm2s_addr"},   ra,        e.raddr);
  endtask

  task automatic set_sof(input int d, input logic ws, input logic rs);
    case (d)
      0: begin bus0.s2mm_sof = ws; bus0.mm2s_sof = rs; end
      1: begin bus1.s2mm_sof = ws; bus1.mm2s_sof = rs; end
      default: begin bus2.s2mm_sof = ws; bus2.mm2s_sof = rs; end
    endcase
  endtask

  // Called at a negedge: pulse sofs for one clock, compare at the next negedge.
  task automatic step(input int d, input logic ws, input logic rs, input exp_t e);
    set_sof(d, ws, rs);
    sb.push_back(e);
    @(negedge clk);
    set_sof(d, 1'b0, 1'b0);
    pop_compare();
  endtask

  task automatic expect_now(input exp_t e);
    sb.push_back(e);
    pop_compare();
  endtask

  task automatic reset_one(input int d);
    case (d)
      0: rst0 = 1'b1;
      1: rst1 = 1'b1;
      default: rst2 = 1'b1;
    endcase
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
  endtask

  exp_t zero_e;
  int wr_e, lat_e, drop_e;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    bus0.buf_addr0 = 32'h1000; bus0.buf_addr1 = 32'h2000; bus0.buf_addr2 = 32'h3000; bus0.buf_addr3 = 32'h4000;
    bus1.buf_addr0 = 32'h1000; bus1.buf_addr1 = 32'h2000; bus1.buf_addr2 = 32'h3000; bus1.buf_addr3 = 32'h4000;
    bus2.buf_addr0 = 32'h1000; bus2.buf_addr1 = 32'h2000; bus2.buf_addr2 = 32'h3000; bus2.buf_addr3 = 32'h4000;
    set_sof(0, 1'b0, 1'b0); set_sof(1, 1'b0, 1'b0); set_sof(2, 1'b0, 1'b0);

    #1;
    zero_e = mk("reset", 0, 0, 0, 0, 0, 0);
    zero_e.waddr = '0; zero_e.raddr = '0;
    expect_now(zero_e);

    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    expect_now(mk("post_reset_load", 0, 0, 0, 0, 0, 0));

    // Writer only, 3 buffers.
    step(0, 1, 0, mk("wr_p1", 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, mk("wr_p2", 0, 1, 0, 0, 1, 0));
    step(0, 1, 0, mk("wr_p3", 0, 2, 0, 1, 1, 1));
    step(0, 1, 0, mk("wr_p4", 0, 0, 0, 2, 1, 2));

    // Reader before any completed frame.
    step(2, 0, 1, mk("rd_early", 2, 0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of a cycle.
    #2 rst0 = 1'b1;
    #1;
    zero_e.tag = "async_reset";
    expect_now(zero_e);
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);

    // Reader takes latest, then simultaneous sofs, then writer skips the reader.
    step(0, 1, 0, mk("rs_first", 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, mk("rs_w2",    0, 1, 0, 0, 1, 0));
    step(0, 0, 1, mk("rs_take0", 0, 1, 0, 0, 1, 0));
    step(0, 1, 0, mk("rs_w3",    0, 2, 0, 1, 1, 0));
    step(0, 1, 1, mk("simul",    0, 0, 1, 2, 1, 0));
    step(0, 0, 1, mk("take2",    0, 0, 2, 2, 1, 0));
    step(0, 1, 0, mk("w_after",  0, 1, 2, 0, 1, 0));
    step(0, 1, 0, mk("w_skip2",  0, 0, 2, 1, 1, 1));

    // Writer blocked by reader parked on buffer 0 (2 -> 0 becomes 1).
    step(2, 1, 0, mk("blk_first", 2, 0, 0, 0, 0, 0));
    step(2, 1, 0, mk("blk_w2",    2, 1, 0, 0, 1, 0));
    step(2, 0, 1, mk("blk_take",  2, 1, 0, 0, 1, 0));
    step(2, 1, 0, mk("blk_w3",    2, 2, 0, 1, 1, 0));
    step(2, 1, 0, mk("blk_w4",    2, 1, 0, 2, 1, 1));

    // Four buffers, reader parked on buffer 2.
    step(1, 1, 0, mk("q_p1",   1, 0, 0, 0, 0, 0));
    step(1, 1, 0, mk("q_p2",   1, 1, 0, 0, 1, 0));
    step(1, 1, 0, mk("q_p3",   1, 2, 0, 1, 1, 1));
    step(1, 1, 0, mk("q_p4",   1, 3, 0, 2, 1, 2));
    step(1, 0, 1, mk("q_take", 1, 3, 2, 2, 1, 2));
    step(1, 1, 0, mk("q_s0",   1, 0, 2, 3, 1, 2));
    step(1, 1, 0, mk("q_s1",   1, 1, 2, 0, 1, 3));
    step(1, 1, 0, mk("q_s2",   1, 3, 2, 1, 1, 4));
    step(1, 1, 0, mk("q_s3",   1, 0, 2, 3, 1, 5));
    step(1, 1, 0, mk("q_s4",   1, 1, 2, 0, 1, 6));
    step(1, 1, 0, mk("q_s5",   1, 3, 2, 1, 1, 7));

    // 2-bit drop counter saturation: 9 writer sofs, 8 completed frames, no reader.
    reset_one(2);
    for (int k = 1; k <= 9; k++) begin
      wr_e   = (k - 1) % 3;
      lat_e  = (k >= 2) ? (k - 2) % 3 : 0;
      drop_e = (k < 3) ? 0 : ((k - 2 > 3) ? 3 : k - 2);
      step(2, 1, 0, mk($sformatf("sat%0d", k), 2, wr_e, 0, lat_e, (k >= 2) ? 1 : 0, drop_e));
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
